// File: rtl/sram_access_arbiter.sv
// Two-port req/done arbiter in front of one asynchronous 16-bit SRAM.
// Optional build macro SRAM_ARB_FIXED_PRIO_EN: port 0 strict priority.
module sram_access_arbiter #(
  parameter int ADDR_W        = 20,
  parameter int DATA_W        = 16,
  parameter int ACCESS_CYCLES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_req0,
  input  logic              i_we_n0,
  input  logic [ADDR_W-1:0] i_addr0,
  input  logic [DATA_W-1:0] i_wdata0,
  output logic              o_done0,
  output logic [DATA_W-1:0] o_rdata0,
  input  logic              i_req1,
  input  logic              i_we_n1,
  input  logic [ADDR_W-1:0] i_addr1,
  input  logic [DATA_W-1:0] i_wdata1,
  output logic              o_done1,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_ce_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_we_n,
  output logic [DATA_W-1:0] o_sram_wdata,
  output logic              o_sram_wdata_oe,
  input  logic [DATA_W-1:0] i_sram_rdata,
  output logic              o_busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] WE_LAST  = 4'(ACCESS_CYCLES - 2);

  state_t      state;
  logic [3:0]  cnt;
  logic        sel;
  logic        op_rd;
  logic        pick;
  logic        g_we_n;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_wdata;

`ifndef SRAM_ARB_FIXED_PRIO_EN
  logic        last;
`endif

  // Choose which requester would win a grant this cycle
  always_comb begin
    pick = 1'b0;
`ifdef SRAM_ARB_FIXED_PRIO_EN
    pick = ~i_req0;
`else
    if (i_req0 && i_req1)
      pick = ~last;
    else
      pick = i_req1;
`endif
  end

  // Steer the winning port's request fields
  always_comb begin
    g_we_n  = pick ? i_we_n1  : i_we_n0;
    g_addr  = pick ? i_addr1  : i_addr0;
    g_wdata = pick ? i_wdata1 : i_wdata0;
  end

  // Access sequencer with registered SRAM strobes and port responses
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state           <= IDLE;
      cnt             <= '0;
      sel             <= 1'b0;
      op_rd           <= 1'b1;
`ifndef SRAM_ARB_FIXED_PRIO_EN
      last            <= 1'b1;
`endif
      o_sram_addr     <= '0;
      o_sram_wdata    <= '0;
      o_sram_ce_n     <= 1'b1;
      o_sram_oe_n     <= 1'b1;
      o_sram_we_n     <= 1'b1;
      o_sram_wdata_oe <= 1'b0;
      o_rdata0        <= '0;
      o_rdata1        <= '0;
      o_done0         <= 1'b0;
      o_done1         <= 1'b0;
      o_busy          <= 1'b0;
    end else begin
      o_done0 <= 1'b0;
      o_done1 <= 1'b0;
      unique case (state)
        IDLE: begin
          if (i_req0 || i_req1) begin
            sel             <= pick;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last            <= pick;
`endif
            op_rd           <= g_we_n;
            o_sram_addr     <= g_addr;
            o_sram_wdata    <= g_wdata;
            o_sram_ce_n     <= 1'b0;
            o_sram_oe_n     <= ~g_we_n;
            o_sram_we_n     <= g_we_n;
            o_sram_wdata_oe <= ~g_we_n;
            o_busy          <= 1'b1;
            cnt             <= '0;
            state           <= ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == CNT_LAST) begin
            o_sram_ce_n     <= 1'b1;
            o_sram_oe_n     <= 1'b1;
            o_sram_we_n     <= 1'b1;
            o_sram_wdata_oe <= 1'b0;
            if (op_rd) begin
              if (sel)
                o_rdata1 <= i_sram_rdata;
              else
                o_rdata0 <= i_sram_rdata;
            end
            o_done0 <= ~sel;
            o_done1 <= sel;
            o_busy  <= 1'b0;
            state   <= DONE;
          end else begin
            cnt <= cnt + 4'd1;
            // Raise we_n one cycle early so addr/data hold past it
            if (cnt == WE_LAST)
              o_sram_we_n <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Randomized bench for sram_access_arbiter with a behavioural SRAM model
// and a scoreboard of expected memory contents and grant order.
`timescale 1ns/1ps
module tb_sram_access_arbiter;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int AC = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          req0 = 0, we_n0 = 1, req1 = 0, we_n1 = 1;
  logic [AW-1:0] addr0 = '0, addr1 = '0;
  logic [DW-1:0] wdata0 = '0, wdata1 = '0;
  logic          done0, done1, ce_n, oe_n, we_n, wdata_oe, busy;
  logic [DW-1:0] rdata0, rdata1, sram_wdata;
  logic [DW-1:0] sram_rdata = '0;
  logic [AW-1:0] sram_addr;

  logic          q_req0 = 0, q_we_n0 = 1, q_req1 = 0, q_we_n1 = 1;
  logic [AW-1:0] q_addr0 = '0, q_addr1 = '0;
  logic [DW-1:0] q_wdata0 = '0, q_wdata1 = '0;
  logic          q_done0, q_done1, q_ce_n, q_oe_n, q_we_n, q_wdata_oe, q_busy;
  logic [DW-1:0] q_rdata0, q_rdata1, q_sram_wdata;
  logic [DW-1:0] q_sram_rdata = '0;
  logic [AW-1:0] q_sram_addr;

  int errors = 0;
  int checks = 0;
  bit ref_last = 1'b1;
  logic [DW-1:0] exp_r0 = '0, exp_r1 = '0;

  logic [DW-1:0] sram    [bit [AW-1:0]];
  logic [DW-1:0] ref_mem [bit [AW-1:0]];
  logic prev_we = 1'b1;

  sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(AC)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(req0), .i_we_n0(we_n0), .i_addr0(addr0), .i_wdata0(wdata0),
    .o_done0(done0), .o_rdata0(rdata0),
    .i_req1(req1), .i_we_n1(we_n1), .i_addr1(addr1), .i_wdata1(wdata1),
    .o_done1(done1), .o_rdata1(rdata1),
    .o_sram_addr(sram_addr), .o_sram_ce_n(ce_n), .o_sram_oe_n(oe_n),
    .o_sram_we_n(we_n), .o_sram_wdata(sram_wdata),
    .o_sram_wdata_oe(wdata_oe), .i_sram_rdata(sram_rdata), .o_busy(busy)
  );

  sram_access_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYCLES(4)) dut4 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req0(q_req0), .i_we_n0(q_we_n0), .i_addr0(q_addr0), .i_wdata0(q_wdata0),
    .o_done0(q_done0), .o_rdata0(q_rdata0),
    .i_req1(q_req1), .i_we_n1(q_we_n1), .i_addr1(q_addr1), .i_wdata1(q_wdata1),
    .o_done1(q_done1), .o_rdata1(q_rdata1),
    .o_sram_addr(q_sram_addr), .o_sram_ce_n(q_ce_n), .o_sram_oe_n(q_oe_n),
    .o_sram_we_n(q_we_n), .o_sram_wdata(q_sram_wdata),
    .o_sram_wdata_oe(q_wdata_oe), .i_sram_rdata(q_sram_rdata), .o_busy(q_busy)
  );

  // Asynchronous SRAM: write commits on the we_n rising edge while selected
  always @(negedge clk) begin
    if (!ce_n && !oe_n)
      sram_rdata = sram.exists(sram_addr) ? sram[sram_addr] : '0;
    if (prev_we == 1'b0 && we_n == 1'b1 && ce_n == 1'b0)
      sram[sram_addr] = sram_wdata;
    prev_we = we_n;
  end

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : '0;
  endfunction

  task automatic run_access(input bit p, input bit wr,
      input logic [AW-1:0] a, input logic [DW-1:0] d,
      output int lat, output int ce_c, output int oe_c, output int we_c,
      output int woe_c, output int ce_we_hi, output int woe_out,
      output int other);
    lat = 0; ce_c = 0; oe_c = 0; we_c = 0;
    woe_c = 0; ce_we_hi = 0; woe_out = 0; other = 0;
    @(negedge clk);
    if (p) begin
      req1 = 1; we_n1 = !wr; addr1 = a; wdata1 = d;
    end else begin
      req0 = 1; we_n0 = !wr; addr0 = a; wdata0 = d;
    end
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (!ce_n) ce_c++;
      if (!oe_n) oe_c++;
      if (!we_n) we_c++;
      if (wdata_oe) woe_c++;
      if (!ce_n && we_n && wr) ce_we_hi++;
      if (wdata_oe && ce_n) woe_out++;
      if (p ? done0 : done1) other++;
      if (p ? done1 : done0) begin
        lat = k;
        break;
      end
    end
    req0 = 0;
    req1 = 0;
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({ce_n, oe_n, we_n, wdata_oe} !== 4'b1110) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 1110", {ce_n, oe_n, we_n, wdata_oe});
    end
    checks++;
    if (sram_addr !== '0 || sram_wdata !== '0) begin
      errors++;
      $display("FAIL reset_bus got addr=%h wdata=%h want 0", sram_addr, sram_wdata);
    end
    checks++;
    if (rdata0 !== '0 || rdata1 !== '0) begin
      errors++;
      $display("FAIL reset_rdata got %h %h want 0 0", rdata0, rdata1);
    end
    checks++;
    if ({done0, done1, busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_flags got %b want 000", {done0, done1, busy});
    end
    checks++;
    if ({q_ce_n, q_oe_n, q_we_n, q_wdata_oe, q_busy} !== 5'b11100 ||
        q_sram_wdata !== '0) begin
      errors++;
      $display("FAIL reset_dut4 got %b wdata=%h want 11100 0",
               {q_ce_n, q_oe_n, q_we_n, q_wdata_oe, q_busy}, q_sram_wdata);
    end
    rst_n = 1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ce_n !== 1'b1) begin
      errors++;
      $display("FAIL idle_no_req got busy=%b ce_n=%b want 0 1", busy, ce_n);
    end
    ref_last = 1'b1;
  endtask

  task automatic test_read_p0;
    int lat, cc, oc, wc, woc, cwh, wout, oth;
    sram[20'h00010] = 16'h1234;
    ref_mem[20'h00010] = 16'h1234;
    run_access(0, 0, 20'h00010, '0, lat, cc, oc, wc, woc, cwh, wout, oth);
    exp_r0 = 16'h1234;
    ref_last = 1'b0;
    checks++;
    if (lat != AC + 1) begin
      errors++;
      $display("FAIL read0_latency got %0d want %0d", lat, AC + 1);
    end
    checks++;
    if (cc != AC || oc != AC || wc != 0) begin
      errors++;
      $display("FAIL read0_strobes got ce=%0d oe=%0d we=%0d want %0d %0d 0",
               cc, oc, wc, AC, AC);
    end
    checks++;
    if (rdata0 !== 16'h1234) begin
      errors++;
      $display("FAIL read0_data got %h want 1234", rdata0);
    end
    checks++;
    if (oth != 0 || rdata1 !== exp_r1) begin
      errors++;
      $display("FAIL read0_other got done1=%0d rdata1=%h want 0 %h",
               oth, rdata1, exp_r1);
    end
  endtask

  task automatic test_write_p1;
    int lat, cc, oc, wc, woc, cwh, wout, oth;
    run_access(1, 1, 20'd9599, 16'hBEEF, lat, cc, oc, wc, woc, cwh, wout, oth);
    ref_mem[20'd9599] = 16'hBEEF;
    ref_last = 1'b1;
    checks++;
    if (wc != 1 || cc != AC || cwh != 1 || oc != 0) begin
      errors++;
      $display("FAIL write1_strobes got we=%0d ce=%0d ce_after_we=%0d oe=%0d want 1 %0d 1 0",
               wc, cc, cwh, oc, AC);
    end
    checks++;
    if (woc != AC || wout != 0) begin
      errors++;
      $display("FAIL write1_wdata_oe got on=%0d outside=%0d want %0d 0", woc, wout, AC);
    end
    checks++;
    if (lat != AC + 1 || oth != 0) begin
      errors++;
      $display("FAIL write1_done got lat=%0d other=%0d want %0d 0", lat, oth, AC + 1);
    end
    checks++;
    if (rdata0 !== exp_r0 || rdata1 !== exp_r1) begin
      errors++;
      $display("FAIL write1_rdata_kept got %h %h want %h %h", rdata0, rdata1, exp_r0, exp_r1);
    end
    run_access(1, 0, 20'd9599, '0, lat, cc, oc, wc, woc, cwh, wout, oth);
    exp_r1 = 16'hBEEF;
    checks++;
    if (rdata1 !== 16'hBEEF || lat != AC + 1) begin
      errors++;
      $display("FAIL readback1 got %h lat=%0d want beef %0d", rdata1, lat, AC + 1);
    end
  endtask

  task automatic test_random;
    int lat, cc, oc, wc, woc, cwh, wout, oth;
    bit p, wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    for (int i = 0; i < 16; i++) begin
      p  = 1'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      a  = AW'($urandom_range(0, 63));
      d  = DW'($urandom);
      run_access(p, wr, a, d, lat, cc, oc, wc, woc, cwh, wout, oth);
      if (wr)
        ref_mem[a] = d;
      else if (p)
        exp_r1 = ref_rd(a);
      else
        exp_r0 = ref_rd(a);
      ref_last = p;
      checks++;
      if (lat != AC + 1 || oth != 0) begin
        errors++;
        $display("FAIL rand_done[%0d] got lat=%0d other=%0d want %0d 0",
                 i, lat, oth, AC + 1);
      end
      checks++;
      if (rdata0 !== exp_r0 || rdata1 !== exp_r1) begin
        errors++;
        $display("FAIL rand_rdata[%0d] got %h %h want %h %h",
                 i, rdata0, rdata1, exp_r0, exp_r1);
      end
    end
  endtask

  task automatic test_fairness;
    int n, last_t;
    bit gp, exp_p;
    n = 0;
    last_t = 0;
    @(negedge clk);
    req0 = 1; we_n0 = 1; addr0 = AW'($urandom_range(0, 63));
    req1 = 1; we_n1 = 1; addr1 = AW'($urandom_range(0, 63));
    for (int k = 1; k <= 200 && n < 6; k++) begin
      @(negedge clk);
      if (done0 && done1) begin
        checks++;
        errors++;
        $display("FAIL fair_double_done got 11 want one-hot at cycle %0d", k);
      end else if (done0 || done1) begin
        gp = done1;
`ifdef SRAM_ARB_FIXED_PRIO_EN
        exp_p = 1'b0;
`else
        exp_p = !ref_last;
`endif
        checks++;
        if (gp !== exp_p) begin
          errors++;
          $display("FAIL fair_order[%0d] got port %0d want port %0d", n, gp, exp_p);
        end
        if (gp) exp_r1 = ref_rd(addr1);
        else    exp_r0 = ref_rd(addr0);
        checks++;
        if (rdata0 !== exp_r0 || rdata1 !== exp_r1) begin
          errors++;
          $display("FAIL fair_rdata[%0d] got %h %h want %h %h",
                   n, rdata0, rdata1, exp_r0, exp_r1);
        end
        if (n > 0) begin
          checks++;
          if (k - last_t != AC + 2) begin
            errors++;
            $display("FAIL fair_gap[%0d] got %0d want %0d", n, k - last_t, AC + 2);
          end
        end
        last_t = k;
        ref_last = gp;
        n++;
        if (gp) addr1 = AW'($urandom_range(0, 63));
        else    addr0 = AW'($urandom_range(0, 63));
      end
    end
    req0 = 0;
    req1 = 0;
    checks++;
    if (n != 6) begin
      errors++;
      $display("FAIL fair_count got %0d want 6", n);
    end
  endtask

  task automatic test_addr_change;
    logic [AW-1:0] a, na;
    logic [DW-1:0] d, nd;
    int nd0, nd1, bad;
    bit got;
    a  = AW'($urandom_range(100, 199));
    na = a + AW'(500);
    d  = DW'($urandom);
    nd = ~d;
    nd0 = 0; nd1 = 0; bad = 0; got = 0;
    @(negedge clk);
    req0 = 1; we_n0 = 0; addr0 = a; wdata0 = d;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (busy) begin
        got = 1;
        break;
      end
    end
    addr0 = na;
    wdata0 = nd;
    req0 = 0;
    for (int k = 0; k < 10; k++) begin
      if (k > 0) @(negedge clk);
      if (!ce_n && (sram_addr !== a || sram_wdata !== d)) bad++;
      if (done0) nd0++;
      if (done1) nd1++;
    end
    ref_mem[a] = d;
    ref_last = 1'b0;
    checks++;
    if (!got || bad != 0) begin
      errors++;
      $display("FAIL latch_hold got granted=%0d bad_cycles=%0d want 1 0", got, bad);
    end
    checks++;
    if (nd0 != 1 || nd1 != 0) begin
      errors++;
      $display("FAIL latch_done got done0=%0d done1=%0d want 1 0", nd0, nd1);
    end
    checks++;
    if (!sram.exists(a) || sram[a] !== d || sram.exists(na)) begin
      errors++;
      $display("FAIL latch_sram got stored_new=%0d want orig %h at %h", sram.exists(na), d, a);
    end
  endtask

  task automatic test_reset_mid;
    int dc;
    bit seen, gp;
    dc = 0; seen = 0; gp = 0;
    @(negedge clk);
    req1 = 1; we_n1 = 0; addr1 = 20'h00300; wdata1 = 16'h5A5A;
    @(negedge clk);
    checks++;
    if (ce_n !== 1'b0 || we_n !== 1'b0) begin
      errors++;
      $display("FAIL midrst_started got ce_n=%b we_n=%b want 0 0", ce_n, we_n);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({ce_n, oe_n, we_n, wdata_oe, busy} !== 5'b11100) begin
      errors++;
      $display("FAIL midrst_async got %b want 11100", {ce_n, oe_n, we_n, wdata_oe, busy});
    end
    req1 = 0;
    repeat (3) begin
      @(negedge clk);
      if (done0 || done1) dc++;
    end
    rst_n = 1;
    exp_r0 = '0;
    exp_r1 = '0;
    ref_last = 1'b1;
    checks++;
    if (dc != 0 || sram.exists(20'h00300) || rdata0 !== '0 || rdata1 !== '0) begin
      errors++;
      $display("FAIL midrst_abort got dones=%0d stored=%0d rdata=%h %h want 0 0 0 0",
               dc, sram.exists(20'h00300), rdata0, rdata1);
    end
    @(negedge clk);
    req0 = 1; we_n0 = 1; addr0 = 20'h00010;
    req1 = 1; we_n1 = 1; addr1 = 20'd9599;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done0 || done1) begin
        seen = 1;
        gp = done1;
        break;
      end
    end
    req0 = 0;
    req1 = 0;
    exp_r0 = ref_rd(20'h00010);
    ref_last = 1'b0;
    checks++;
    if (!seen || gp !== 1'b0 || rdata0 !== exp_r0) begin
      errors++;
      $display("FAIL midrst_first_tie got seen=%0d port=%0d rdata0=%h want 1 0 %h",
               seen, gp, rdata0, exp_r0);
    end
    @(negedge clk);
  endtask

  task automatic test_access4;
    int oc, cc, wc, lat, d1, badaddr;
    logic [DW-1:0] cap;
    for (int r = 0; r < 4; r++) begin
      oc = 0; cc = 0; wc = 0; lat = 0; d1 = 0; badaddr = 0;
      cap = '0;
      @(negedge clk);
      @(negedge clk);
      q_req0 = 1; q_we_n0 = 1; q_addr0 = AW'($urandom);
      for (int k = 1; k <= 30; k++) begin
        @(negedge clk);
        if (!q_ce_n) begin
          cc++;
          if (q_sram_addr !== q_addr0) badaddr++;
        end
        if (!q_we_n || q_wdata_oe) wc++;
        if (q_done1) d1++;
        if (!q_oe_n) begin
          oc++;
          q_sram_rdata = DW'($urandom);
          if (oc == 4) cap = q_sram_rdata;
        end
        if (q_done0) begin
          lat = k;
          break;
        end
      end
      q_req0 = 0;
      checks++;
      if (oc != 4 || cc != 4 || wc != 0 || badaddr != 0) begin
        errors++;
        $display("FAIL ac4_strobes[%0d] got oe=%0d ce=%0d wr=%0d badaddr=%0d want 4 4 0 0",
                 r, oc, cc, wc, badaddr);
      end
      checks++;
      if (lat != 5 || d1 != 0) begin
        errors++;
        $display("FAIL ac4_latency[%0d] got %0d done1=%0d want 5 0", r, lat, d1);
      end
      checks++;
      if (q_rdata0 !== cap || q_rdata1 !== '0 || q_busy !== 1'b0) begin
        errors++;
        $display("FAIL ac4_data[%0d] got %h rdata1=%h busy=%b want %h 0 0",
                 r, q_rdata0, q_rdata1, q_busy, cap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_read_p0();
    test_write_p1();
    test_random();
    test_fairness();
    test_addr_change();
    test_reset_mid();
    test_access4();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/sram_access_arbiter.md
Name: sram_access_arbiter

Overview:
- Shares the single external 16-bit SRAM between two effect requesters: port 0 = chorus delay line, port 1 = echo/delay line.
- Each requester issues one read or write at a time with a req/done handshake.
- The arbiter serialises accesses, drives the SRAM control pins with fixed timing, and returns read data to the owning port.
- Sits between the effect chain and the top-level SRAM pins.

Parameters:
- ADDR_W, 20, SRAM word address width.
- DATA_W, 16, SRAM data width.
- ACCESS_CYCLES, 2, clock cycles per SRAM access; legal range 2..15.

Ports:
- i_clk  in  1  system clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req0  in  1  port 0 access request, level; held until o_done0
- i_we_n0  in  1  port 0: 0 = write, 1 = read
- i_addr0  in  ADDR_W  port 0 address
- i_wdata0  in  DATA_W  port 0 write data
- o_done0  out  1  port 0 access complete, 1-cycle pulse
- o_rdata0  out  DATA_W  port 0 read data; valid from o_done0, held until the next port 0 read completes
- i_req1, i_we_n1, i_addr1, i_wdata1, o_done1, o_rdata1: same as the port 0 signals, for port 1
- o_sram_addr  out  ADDR_W  SRAM address
- o_sram_ce_n  out  1  chip enable, active low
- o_sram_oe_n  out  1  output enable, active low
- o_sram_we_n  out  1  write enable, active low
- o_sram_wdata  out  DATA_W  data to SRAM
- o_sram_wdata_oe  out  1  1 = top level drives the data bus
- i_sram_rdata  in  DATA_W  data from SRAM
- o_busy  out  1  access in progress

Behaviour:
- Reset (async, i_rst_n=0), all outputs registered:
  - ce_n/oe_n/we_n = 1; wdata_oe = 0.
  - sram_addr, sram_wdata, rdata0/1 = 0.
  - done0/1 = 0; busy = 0.
  - state = IDLE; round-robin pointer last = 1, so port 0 wins the first tie.
  - Reset during an access aborts it immediately; no done pulse is issued.
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any req is high, select a port:
    - only one req high: that port.
    - both high: the port != last.
  - Latch that port's addr, we_n and wdata into o_sram_addr/o_sram_wdata.
  - Set last = selected port, busy = 1, counter = 0; go to ACCESS.
- ACCESS, lasting ACCESS_CYCLES cycles, counter 0..ACCESS_CYCLES-1:
  - ce_n = 0 throughout.
  - Read: oe_n = 0 throughout; wdata_oe = 0. On the edge ending the last ACCESS cycle, i_sram_rdata is captured into the selected port's o_rdata.
  - Write: wdata_oe = 1 throughout. we_n = 0 for counter < ACCESS_CYCLES-1 and we_n = 1 in the last cycle, so address and data hold across the we_n rising edge.
  - After the last cycle: go to DONE.
- DONE, one cycle:
  - ce_n/oe_n/we_n = 1; wdata_oe = 0.
  - Selected port's done = 1; busy = 0.
  - Requests are not sampled in this cycle.
  - Return to IDLE.
- Latency:
  - req sampled high in IDLE at edge t → SRAM controls asserted t+1 … t+ACCESS_CYCLES → done pulse in cycle t+ACCESS_CYCLES+1.
  - Back-to-back grants are separated by one DONE cycle plus one IDLE cycle.
- Requester rules:
  - Requester deasserts req on the edge after seeing done, or keeps it high to queue the next access.
  - addr/we_n/wdata are latched at grant, so later changes do not affect the access in flight.
  - req dropped mid-access: the access still completes and done still pulses.
- Fairness: with both ports continuously requesting, grants alternate 0,1,0,1…
- The port not granted never sees done; its o_rdata is unchanged.
- A write never modifies either o_rdata.

Optional Feature:
- Macro: SRAM_ARB_FIXED_PRIO_EN.
- Defined:
  - Port 0 always wins ties (strict priority).
  - The last pointer is not used.
  - Port 1 is served only when req0 is low in IDLE.
- Undefined: round-robin as above.

Test Plan:
- Reset, then single read, port 0 (addr 0x00010, SRAM model returns 0x1234, ACCESS_CYCLES=2):
  - ce_n/oe_n low for exactly 2 cycles.
  - done0 pulses 3 cycles after req0 is sampled.
  - o_rdata0 = 0x1234; done1 stays 0.
- Write then readback, port 1 (write 0xBEEF to addr 9599, then read it):
  - we_n low for exactly 1 cycle, and ce_n stays low one cycle after we_n rises.
  - wdata_oe high only during ACCESS.
  - Readback o_rdata1 = 0xBEEF.
- Simultaneous req0 and req1 held high for 6 accesses:
  - Grant order 0,1,0,1,0,1.
  - With SRAM_ARB_FIXED_PRIO_EN defined, all 6 grants go to port 0.
- Port 0 changes addr and wdata one cycle after grant:
  - The SRAM sees the originally latched values.
  - Exactly one done0 pulse.
- Reset asserted mid-ACCESS:
  - All SRAM controls return high and wdata_oe = 0 asynchronously.
  - No done pulse; after release, the first tie goes to port 0.
- ACCESS_CYCLES=4 read:
  - oe_n low for exactly 4 cycles.
  - done at cycle t+5; captured data is the value present in the 4th cycle.
